// File: rtl/rtc_alarm_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rtc_alarm_sched_if                                     |
// | Description : Register-file side bundle of the RTC alarm scheduler:  |
// |               current time, slot configuration, acknowledge and      |
// |               status/interrupt outputs.                              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface rtc_alarm_sched_if #(
  parameter int N_ALARMS = 4
);
  localparam int IDX_W = $clog2(N_ALARMS);

  logic [42:0]         cur_time_i;
  logic                cfg_we_i;
  logic [IDX_W-1:0]    cfg_idx_i;
  logic [42:0]         cfg_time_i;
  logic [7:0]          cfg_mask_i;
  logic                cfg_oneshot_i;
  logic                cfg_arm_i;
  logic                ack_i;
  logic [IDX_W-1:0]    ack_idx_i;
  logic [N_ALARMS-1:0] pending_o;
  logic [N_ALARMS-1:0] armed_o;
  logic [IDX_W-1:0]    hit_idx_o;
  logic                busy_o;
  logic                ir_o;

  // Register file / time counter side
  modport master (
    output cur_time_i, cfg_we_i, cfg_idx_i, cfg_time_i, cfg_mask_i,
           cfg_oneshot_i, cfg_arm_i, ack_i, ack_idx_i,
    input  pending_o, armed_o, hit_idx_o, busy_o, ir_o
  );

  // Scheduler side
  modport slave (
    input  cur_time_i, cfg_we_i, cfg_idx_i, cfg_time_i, cfg_mask_i,
           cfg_oneshot_i, cfg_arm_i, ack_i, ack_idx_i,
    output pending_o, armed_o, hit_idx_o, busy_o, ir_o
  );
endinterface
`default_nettype wire

// File: rtl/rtc_alarm_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rtc_alarm_sched                                        |
// | Description : Multi-slot alarm scheduler. Each change of the current |
// |               calendar time starts a scan that compares one slot per |
// |               cycle against a snapshot and latches pending flags;    |
// |               a level interrupt is held until software acknowledges. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module rtc_alarm_sched #(
  parameter int N_ALARMS = 4
) (
  input wire               clk_i,
  input wire               rst_i,
  rtc_alarm_sched_if.slave bus
);
  localparam int               IDX_W      = $clog2(N_ALARMS);
  localparam int               C_TW       = 43;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_ALARMS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic [IDX_W-1:0]    r_scan_idx;
  logic [C_TW-1:0]     r_snapshot;
  logic [C_TW-1:0]     r_snap_next;
  logic                r_rescan;
  logic [C_TW-1:0]     r_prev_time;
  logic                r_valid;
  logic [C_TW-1:0]     r_slot_time [N_ALARMS];
  logic [7:0]          r_slot_mask [N_ALARMS];
  logic [N_ALARMS-1:0] r_oneshot;
  logic [N_ALARMS-1:0] r_armed;
  logic [N_ALARMS-1:0] r_pending;
  logic [IDX_W-1:0]    r_hit_idx;
  logic                r_ir;

  logic                w_tick;
  logic                w_last;
  logic [N_ALARMS-1:0] w_match;
  logic [N_ALARMS-1:0] w_wr_sel;
  logic [N_ALARMS-1:0] w_ack_sel;
  logic [IDX_W-1:0]    w_hit;

  // Field-wise compare; a set mask bit makes that field always equal.
  // Field order (LSB first): sec, min, hour, mode, dow, dom, month, year.
  function automatic logic f_match(input logic [C_TW-1:0] a,
                                   input logic [C_TW-1:0] b,
                                   input logic [7:0]      m);
    logic [7:0] eq;
    eq[0] = (a[5:0]   == b[5:0]);
    eq[1] = (a[11:6]  == b[11:6]);
    eq[2] = (a[16:12] == b[16:12]);
    eq[3] = (a[18:17] == b[18:17]);
    eq[4] = (a[21:19] == b[21:19]);
    eq[5] = (a[26:22] == b[26:22]);
    eq[6] = (a[30:27] == b[30:27]);
    eq[7] = (a[42:31] == b[42:31]);
    return &(eq | m);
  endfunction

  assign w_tick = r_valid && (bus.cur_time_i != r_prev_time);
  assign w_last = (r_scan_idx == C_LAST_IDX);

  // Per-slot select decodes; out-of-range indices never select a slot.
  generate
    for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
      assign w_wr_sel[i]  = bus.cfg_we_i && (bus.cfg_idx_i == IDX_W'(i));
      assign w_ack_sel[i] = bus.ack_i && (bus.ack_idx_i == IDX_W'(i));
      assign w_match[i]   = r_busy && (r_scan_idx == IDX_W'(i)) && r_armed[i] &&
                            f_match(r_slot_time[i], r_snapshot, r_slot_mask[i]);
    end
  endgenerate

  // Lowest-index pending slot, zero when nothing is pending.
  always_comb begin
    w_hit = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_hit = IDX_W'(i);
    end
  end

  // Previous-time tracker; first cycle after reset only primes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev_time <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_prev_time <= bus.cur_time_i;
      r_valid     <= 1'b1;
    end
  end

  // Scan sequencer: one slot per cycle, newest tick during a scan queues a rescan.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_scan_idx  <= '0;
      r_snapshot  <= '0;
      r_snap_next <= '0;
      r_rescan    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state    <= S_SCAN;
            r_busy     <= 1'b1;
            r_snapshot <= bus.cur_time_i;
            r_scan_idx <= '0;
            r_rescan   <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_last) begin
            r_scan_idx <= '0;
            r_rescan   <= 1'b0;
            if (w_tick) begin
              // A tick on the final compare is newer than any queued one.
              r_snapshot <= bus.cur_time_i;
            end else if (r_rescan) begin
              r_snapshot <= r_snap_next;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
            if (w_tick) begin
              r_rescan    <= 1'b1;
              r_snap_next <= bus.cur_time_i;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Slot storage: write beats match, match beats acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        r_slot_time[i] <= '0;
        r_slot_mask[i] <= '0;
      end
      r_oneshot <= '0;
      r_armed   <= '0;
      r_pending <= '0;
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (w_wr_sel[i]) begin
          r_slot_time[i] <= bus.cfg_time_i;
          r_slot_mask[i] <= bus.cfg_mask_i;
          r_oneshot[i]   <= bus.cfg_oneshot_i;
          r_armed[i]     <= bus.cfg_arm_i;
          r_pending[i]   <= 1'b0;
        end else if (w_match[i]) begin
          r_pending[i] <= 1'b1;
          if (r_oneshot[i]) r_armed[i] <= 1'b0;
        end else if (w_ack_sel[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Interrupt and hit index follow the pending flags by one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ir      <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_ir      <= |r_pending;
      r_hit_idx <= w_hit;
    end
  end

  assign bus.pending_o = r_pending;
  assign bus.armed_o   = r_armed;
  assign bus.hit_idx_o = r_hit_idx;
  assign bus.busy_o    = r_busy;
  assign bus.ir_o      = r_ir;
endmodule
`default_nettype wire

// File: tb/tb_rtc_alarm_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rtc_alarm_sched                                     |
// | Description : Self-checking bench for rtc_alarm_sched: directed      |
// |               scenarios plus randomized traffic against a schedule-  |
// |               level reference model.                                 |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_rtc_alarm_sched;
  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int LO [8] = '{0, 6, 12, 17, 19, 22, 27, 31};
  localparam int WD [8] = '{6, 6, 5, 2, 3, 5, 4, 12};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  rtc_alarm_sched_if #(.N_ALARMS(N)) bus ();

  rtc_alarm_sched #(.N_ALARMS(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [42:0] mk(input int yr, input int mo, input int dm, input int dw,
                                     input int md, input int hr, input int mi, input int se);
    return {yr[11:0], mo[3:0], dm[4:0], dw[2:0], md[1:0], hr[4:0], mi[5:0], se[5:0]};
  endfunction

  function automatic bit fields_match(input logic [42:0] a, input logic [42:0] b,
                                      input logic [7:0] m);
    for (int f = 0; f < 8; f++) begin
      longint unsigned fm, fa, fb;
      fm = (64'd1 << WD[f]) - 64'd1;
      fa = (64'(a) >> LO[f]) & fm;
      fb = (64'(b) >> LO[f]) & fm;
      if (!m[f] && fa != fb) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Scan windows are tracked by edge number: a scan started at edge s decides
  // slot k at edge s+1+k; a queued rescan starts at the edge its window ends.
  int              edge_n, sc_start;
  bit              sc_active, rs_pend, m_valid;
  logic [42:0]     m_prev, sc_snap, rs_val;
  logic [42:0]     m_time [N];
  logic [7:0]      m_mask [N];
  bit   [N-1:0]    m_os, m_arm, m_pend;
  bit              m_ir;
  int              m_hit;

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        edge_n = 0; sc_start = 0; sc_active = 0; rs_pend = 0; m_valid = 0;
        m_prev = '0; sc_snap = '0; rs_val = '0;
        for (int i = 0; i < N; i++) begin m_time[i] = '0; m_mask[i] = '0; end
        m_os = '0; m_arm = '0; m_pend = '0; m_ir = 0; m_hit = 0;
      end else begin
        int k, hit_slot;
        bit tick;
        edge_n++;
        k = sc_active ? (edge_n - sc_start - 1) : -1;
        hit_slot = -1;
        if (k >= 0 && k < N && m_arm[k] && fields_match(m_time[k], sc_snap, m_mask[k]))
          hit_slot = k;
        tick = m_valid && (bus.cur_time_i != m_prev);
        m_ir  = (m_pend != 0);
        m_hit = 0;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_hit = i;
        if (hit_slot >= 0) begin
          m_pend[hit_slot] = 1'b1;
          if (m_os[hit_slot]) m_arm[hit_slot] = 1'b0;
        end
        if (bus.ack_i && int'(bus.ack_idx_i) != hit_slot) m_pend[bus.ack_idx_i] = 1'b0;
        if (bus.cfg_we_i) begin
          m_time[bus.cfg_idx_i] = bus.cfg_time_i;
          m_mask[bus.cfg_idx_i] = bus.cfg_mask_i;
          m_os[bus.cfg_idx_i]   = bus.cfg_oneshot_i;
          m_arm[bus.cfg_idx_i]  = bus.cfg_arm_i;
          m_pend[bus.cfg_idx_i] = 1'b0;
        end
        if (sc_active && k < N - 1) begin
          if (tick) begin rs_pend = 1; rs_val = bus.cur_time_i; end
        end else if (tick) begin
          sc_active = 1; sc_start = edge_n; sc_snap = bus.cur_time_i; rs_pend = 0;
        end else if (rs_pend) begin
          sc_active = 1; sc_start = edge_n; sc_snap = rs_val; rs_pend = 0;
        end else begin
          sc_active = 0;
        end
        m_prev  = bus.cur_time_i;
        m_valid = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("pending", 64'(bus.pending_o), 64'(m_pend));
      chk("armed",   64'(bus.armed_o),   64'(m_arm));
      chk("busy",    64'(bus.busy_o),    64'(sc_active));
      chk("ir",      64'(bus.ir_o),      64'(m_ir));
      chk("hit_idx", 64'(bus.hit_idx_o), 64'(m_hit));
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic cfg_write(input int idx, input logic [42:0] t, input logic [7:0] m,
                           input bit os, input bit arm);
    @(negedge clk);
    bus.cfg_we_i = 1'b1; bus.cfg_idx_i = IDX_W'(idx); bus.cfg_time_i = t;
    bus.cfg_mask_i = m; bus.cfg_oneshot_i = os; bus.cfg_arm_i = arm;
    @(negedge clk);
    bus.cfg_we_i = 1'b0;
  endtask

  task automatic do_ack(input int idx);
    @(negedge clk);
    bus.ack_i = 1'b1; bus.ack_idx_i = IDX_W'(idx);
    @(negedge clk);
    bus.ack_i = 1'b0;
  endtask

  task automatic set_time(input logic [42:0] t);
    @(negedge clk);
    bus.cur_time_i = t;
  endtask

  function automatic logic [42:0] rnd_time();
    return mk(0, 0, int'($urandom_range(0, 1)), 0, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [N-1:0] busy_hist;
    int run;
    bus.cur_time_i = '0; bus.cfg_we_i = 0; bus.cfg_idx_i = '0; bus.cfg_time_i = '0;
    bus.cfg_mask_i = '0; bus.cfg_oneshot_i = 0; bus.cfg_arm_i = 0;
    bus.ack_i = 0; bus.ack_idx_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_pending", 64'(bus.pending_o), 64'd0);
    chk("rst_armed",   64'(bus.armed_o),   64'd0);
    chk("rst_busy",    64'(bus.busy_o),    64'd0);
    chk("rst_ir",      64'(bus.ir_o),      64'd0);
    chk("rst_hit",     64'(bus.hit_idx_o), 64'd0);
    rst = 1'b0;

    // 1: slot 2 at 12:30:00, date ignored
    cfg_write(2, mk(0, 0, 0, 0, 0, 12, 30, 0), 8'hF8, 1'b0, 1'b1);
    set_time(mk(0, 0, 0, 0, 0, 12, 30, 0));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) chk("t1_busy", 64'(bus.busy_o), 64'd1);
      if (k == 2) chk("t1_pend_e2", 64'(bus.pending_o), 64'h0);
      if (k == 3) begin
        chk("t1_pend_e3", 64'(bus.pending_o), 64'h4);
        chk("t1_ir_e3", 64'(bus.ir_o), 64'd0);
      end
      if (k == 4) begin
        chk("t1_ir_e4", 64'(bus.ir_o), 64'd1);
        chk("t1_hit_e4", 64'(bus.hit_idx_o), 64'd2);
        chk("t1_busy_e4", 64'(bus.busy_o), 64'd0);
      end
    end
    do_ack(2);
    repeat (2) @(negedge clk);
    chk("t1_ir_after_ack", 64'(bus.ir_o), 64'd0);
    cfg_write(2, mk(0, 0, 0, 0, 0, 12, 30, 0), 8'hF8, 1'b0, 1'b0);

    // 2: one-shot vs repeat on seconds==0
    cfg_write(0, '0, 8'hFE, 1'b1, 1'b1);
    cfg_write(1, '0, 8'hFE, 1'b0, 1'b1);
    set_time(mk(0, 0, 0, 0, 0, 12, 30, 59)); repeat (6) @(negedge clk);
    set_time(mk(0, 0, 0, 0, 0, 12, 31, 0));  repeat (6) @(negedge clk);
    chk("t2_pend1", 64'(bus.pending_o), 64'h3);
    chk("t2_arm1",  64'(bus.armed_o),   64'h2);
    do_ack(0); do_ack(1); repeat (2) @(negedge clk);
    chk("t2_ir_clr", 64'(bus.ir_o), 64'd0);
    set_time(mk(0, 0, 0, 0, 0, 12, 31, 59)); repeat (6) @(negedge clk);
    set_time(mk(0, 0, 0, 0, 0, 12, 32, 0));  repeat (6) @(negedge clk);
    chk("t2_pend2", 64'(bus.pending_o), 64'h2);
    chk("t2_arm2",  64'(bus.armed_o),   64'h2);
    do_ack(1); repeat (2) @(negedge clk);

    // 3: ack in the same cycle slot 3 matches again
    cfg_write(3, '0, 8'hFF, 1'b0, 1'b1);
    set_time(mk(0, 0, 0, 0, 0, 12, 32, 7)); repeat (8) @(negedge clk);
    chk("t3_pend_pre", 64'(bus.pending_o[3]), 64'd1);
    set_time(mk(0, 0, 0, 0, 0, 12, 32, 9));
    repeat (4) @(negedge clk);
    bus.ack_i = 1'b1; bus.ack_idx_i = 2'd3;
    @(negedge clk);
    bus.ack_i = 1'b0;
    chk("t3_pend_race", 64'(bus.pending_o[3]), 64'd1);
    @(negedge clk);
    chk("t3_ir_race", 64'(bus.ir_o), 64'd1);
    cfg_write(3, '0, 8'hFF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // 4: second tick two cycles into a scan
    cfg_write(0, mk(0, 0, 0, 0, 0, 13, 40, 5), 8'hF8, 1'b0, 1'b1);
    cfg_write(2, mk(0, 0, 0, 0, 0, 13, 41, 7), 8'hF8, 1'b0, 1'b1);
    set_time(mk(0, 0, 0, 0, 0, 13, 40, 5));
    run = 0; busy_hist = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.busy_o) run++;
      if (k == 1) bus.cur_time_i = mk(0, 0, 0, 0, 0, 13, 41, 7);
      if (k == 8) busy_hist[0] = bus.busy_o;
    end
    chk("t4_busy_run", 64'(run), 64'd8);
    chk("t4_busy_end", 64'(busy_hist[0]), 64'd0);
    chk("t4_pend", 64'(bus.pending_o), 64'h5);
    cfg_write(0, '0, 8'h00, 1'b0, 1'b0);
    cfg_write(2, '0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // 5: disarming write to slot 1 in its own compare cycle
    set_time(mk(0, 0, 0, 0, 0, 13, 42, 0));
    @(negedge clk);
    cfg_write(1, '0, 8'hFE, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_ir", 64'(bus.ir_o), 64'd0);
    end
    chk("t5_pend1", 64'(bus.pending_o[1]), 64'd0);
    chk("t5_arm1",  64'(bus.armed_o[1]),   64'd0);

    // 6: reset in the second cycle of a scan
    cfg_write(0, '0, 8'hFF, 1'b0, 1'b1);
    set_time(mk(0, 0, 0, 0, 0, 13, 42, 3)); repeat (6) @(negedge clk);
    chk("t6_pend_pre", 64'(bus.pending_o), 64'h1);
    set_time(mk(0, 0, 0, 0, 0, 13, 42, 4));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_pending", 64'(bus.pending_o), 64'd0);
    chk("t6_armed",   64'(bus.armed_o),   64'd0);
    chk("t6_busy",    64'(bus.busy_o),    64'd0);
    chk("t6_ir",      64'(bus.ir_o),      64'd0);
    chk("t6_hit",     64'(bus.hit_idx_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_scan", 64'(bus.busy_o), 64'd0);
    end

    // Randomized traffic over a small time domain so matches are frequent
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) bus.cur_time_i = rnd_time();
      bus.cfg_we_i      = ($urandom_range(0, 7) == 0);
      bus.cfg_idx_i     = IDX_W'($urandom_range(0, N - 1));
      bus.cfg_time_i    = rnd_time();
      bus.cfg_mask_i    = 8'($urandom_range(0, 255)) | (($urandom_range(0, 1) == 1) ? 8'hF8 : 8'h00);
      bus.cfg_oneshot_i = ($urandom_range(0, 1) == 1);
      bus.cfg_arm_i     = ($urandom_range(0, 3) != 0);
      bus.ack_i         = ($urandom_range(0, 2) == 0);
      bus.ack_idx_i     = IDX_W'($urandom_range(0, N - 1));
    end
    @(negedge clk);
    bus.cfg_we_i = 1'b0; bus.ack_i = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
